apb4_slave_bridge: RTL and testbench

- APB4 completer that converts PSEL/PENABLE transfers into a level-handshake SRAM/peripheral request (re/we plus address, data and byte selects).
- Generalises the fixed-width, strobe-less bridge: it adds byte strobes, address-window decode, a registered read-data path, and wait-state handling with timeout to PSLVERR.
- Sits between the APB interconnect select output and one memory-like slave.

---
 rtl/apb_bridge_pkg.sv | 21 ++
 rtl/apb_wait_timer.sv | 37 +++
 rtl/apb4_slave_bridge.sv | 141 ++++++++++++++
 tb/tb_apb4_slave_bridge.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the APB4 slave bridge.
package apb_bridge_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    localparam int unsigned PPROT_PRIV_BIT  = 0;
    localparam int unsigned PPROT_NSEC_BIT  = 1;
    localparam int unsigned PPROT_INSTR_BIT = 2;

    function automatic int unsigned strb_w(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Subtract-then-compare so base+size never needs to be representable.
    function automatic logic in_window(input logic [63:0] a,
                                       input logic [63:0] base,
                                       input logic [63:0] size);
        return (a >= base) && ((a - base) < size);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles; expired flags the last allowed cycle (TIMEOUT_CYCLES=0 never expires).
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturate at LAST so a disabled timer never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_W'(LAST))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt_q == CNT_W'(LAST));

endmodule

// File: rtl/apb4_slave_bridge.sv
// APB4 completer to level-handshake memory bridge with window decode and wait timeout.
// Optional macro APB_PPROT_CHECK_EN rejects non-secure or unprivileged accesses.
module apb4_slave_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [63:0] ADDR_BASE      = 64'h0,
    parameter logic [63:0] ADDR_SIZE      = 64'h1000,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned STRB_W        = strb_w(DATA_WIDTH)
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_W-1:0]     PSTRB,
    input  logic [2:0]            PPROT,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  re,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_W-1:0]     sel,
    input  logic                  slave_rdy,
    input  logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned LSB = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     sel_q, sel_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  expired;
    logic                  prot_err_c;
    logic                  unused_pprot;

`ifdef APB_PPROT_CHECK_EN
    assign prot_err_c = PPROT[PPROT_NSEC_BIT] || !PPROT[PPROT_PRIV_BIT];
`else
    assign prot_err_c = 1'b0;
`endif
    assign unused_pprot = ^pprot_q;

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        pprot_d  = pprot_q;
        prdata_d = prdata_q;
        unique case (state_q)
            IDLE: begin
                // PSEL with PENABLE already high in IDLE is a protocol error and is ignored.
                if (PSEL && !PENABLE) begin
                    write_d = PWRITE;
                    addr_d  = PADDR & ALIGN_MASK;
                    wdata_d = PWDATA;
                    sel_d   = PWRITE ? PSTRB : '1;
                    pprot_d = PPROT;
                    if (!in_window(64'(PADDR), ADDR_BASE, ADDR_SIZE) || prot_err_c) begin
                        state_d  = ERR;
                        prdata_d = '0;
                    end else if (PWRITE && (PSTRB == '0)) begin
                        state_d = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (slave_rdy) begin
                    state_d = RESP;
                    if (!write_q) begin
                        prdata_d = rdata;
                    end
                end else if (expired) begin
                    state_d  = ERR;
                    prdata_d = '0;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            pprot_q  <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            pprot_q  <= pprot_d;
            prdata_q <= prdata_d;
        end
    end

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .en     (state_q == ACCESS),
        .clr    (state_d != ACCESS),
        .expired(expired)
    );

    // Slave-side request is only visible while in ACCESS.
    assign re      = (state_q == ACCESS) && !write_q;
    assign we      = (state_q == ACCESS) && write_q;
    assign addr    = (state_q == ACCESS) ? addr_q  : '0;
    assign wdata   = (state_q == ACCESS) ? wdata_q : '0;
    assign sel     = (state_q == ACCESS) ? sel_q   : '0;
    assign PREADY  = (state_q == RESP) || (state_q == ERR);
    assign PSLVERR = (state_q == ERR);
    assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb4_slave_bridge.sv
// Directed bench for apb4_slave_bridge; honours APB_PPROT_CHECK_EN for the PPROT scenario.
module tb_apb4_slave_bridge;

    logic        PCLK, PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB, sel;
    logic [2:0]  PPROT;
    logic        PREADY, PSLVERR, re, we, slave_rdy;
    logic [31:0] addr, wdata, rdata;

    int total = 0;
    int bad   = 0;

    apb4_slave_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_BASE(64'h0),
        .ADDR_SIZE(64'h1000), .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .re(re), .we(we), .addr(addr), .wdata(wdata), .sel(sel),
        .slave_rdy(slave_rdy), .rdata(rdata)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    // Setup phase for one cycle, then enter the access phase; returns at T1.
    task automatic setup(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s; PPROT = p;
        tick();
        PENABLE = 1'b1;
    endtask

    task automatic release_bus;
        PSEL = 1'b0; PENABLE = 1'b0; slave_rdy = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        repeat (2) @(posedge PCLK);
        #1;
        total++; if ({PREADY, PSLVERR, re, we} !== 4'b0) begin bad++; $display("FAIL rst_ctrl got=%b exp=0000", {PREADY, PSLVERR, re, we}); end
        total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL rst_prdata got=%h exp=0", PRDATA); end
        total++; if ({addr, wdata, sel} !== 68'h0) begin bad++; $display("FAIL rst_bus got=%h exp=0", {addr, wdata, sel}); end
        PRESETn = 1'b1;
        tick();
    endtask

    task automatic test_write;
        setup(1'b1, 32'h10, 32'hDEADBEEF, 4'b0101, 3'b001);
        total++; if ({we, re} !== 2'b10) begin bad++; $display("FAIL wr_we_re got=%b exp=10", {we, re}); end
        total++; if (addr !== 32'h10) begin bad++; $display("FAIL wr_addr got=%h exp=00000010", addr); end
        total++; if (sel !== 4'b0101) begin bad++; $display("FAIL wr_sel got=%b exp=0101", sel); end
        total++; if (wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_wdata got=%h exp=deadbeef", wdata); end
        total++; if (PREADY !== 1'b0) begin bad++; $display("FAIL wr_t1_pready got=%b exp=0", PREADY); end
        slave_rdy = 1'b1;
        tick();
        total++; if ({PREADY, PSLVERR, we} !== 3'b100) begin bad++; $display("FAIL wr_t2_resp got=%b exp=100", {PREADY, PSLVERR, we}); end
        release_bus();
        total++; if (PREADY !== 1'b0) begin bad++; $display("FAIL wr_idle_pready got=%b exp=0", PREADY); end
    endtask

    task automatic test_read_wait;
        setup(1'b0, 32'h13, 32'h0, 4'b0000, 3'b001);
        total++; if ({re, we} !== 2'b10) begin bad++; $display("FAIL rd_re_we got=%b exp=10", {re, we}); end
        total++; if (addr !== 32'h10) begin bad++; $display("FAIL rd_addr got=%h exp=00000010", addr); end
        total++; if (sel !== 4'b1111) begin bad++; $display("FAIL rd_sel got=%b exp=1111", sel); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if ({re, PREADY} !== 2'b10) begin bad++; $display("FAIL rd_wait%0d got=%b exp=10", i, {re, PREADY}); end
        end
        slave_rdy = 1'b1; rdata = 32'h12345678;
        tick();
        slave_rdy = 1'b0; rdata = 32'hFFFFFFFF;
        total++; if ({PREADY, PSLVERR, re} !== 3'b100) begin bad++; $display("FAIL rd_resp got=%b exp=100", {PREADY, PSLVERR, re}); end
        total++; if (PRDATA !== 32'h12345678) begin bad++; $display("FAIL rd_prdata got=%h exp=12345678", PRDATA); end
        release_bus();
        total++; if (PRDATA !== 32'h12345678) begin bad++; $display("FAIL rd_prdata_hold got=%h exp=12345678", PRDATA); end
    endtask

    task automatic test_reset_mid;
        setup(1'b0, 32'h60, 32'h0, 4'b0000, 3'b001);
        total++; if (re !== 1'b1) begin bad++; $display("FAIL rstmid_re_before got=%b exp=1", re); end
        #1 PRESETn = 1'b0;
        #1;
        total++; if ({re, PREADY} !== 2'b00) begin bad++; $display("FAIL rstmid_ctrl got=%b exp=00", {re, PREADY}); end
        total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL rstmid_prdata got=%h exp=0", PRDATA); end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK) PRESETn = 1'b1;
        tick();
        setup(1'b0, 32'h64, 32'h0, 4'b0000, 3'b001);
        slave_rdy = 1'b1; rdata = 32'hCAFEF00D;
        tick();
        total++; if ({PREADY, PSLVERR} !== 2'b10) begin bad++; $display("FAIL rstmid_next_resp got=%b exp=10", {PREADY, PSLVERR}); end
        total++; if (PRDATA !== 32'hCAFEF00D) begin bad++; $display("FAIL rstmid_next_prdata got=%h exp=cafef00d", PRDATA); end
        release_bus();
    endtask

    task automatic test_timeout;
        int n;
        setup(1'b0, 32'h20, 32'h0, 4'b0000, 3'b001);
        n = 0;
        while (re === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        total++; if (n !== 16) begin bad++; $display("FAIL to_re_cycles got=%0d exp=16", n); end
        total++; if ({PREADY, PSLVERR} !== 2'b11) begin bad++; $display("FAIL to_resp got=%b exp=11", {PREADY, PSLVERR}); end
        total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL to_prdata got=%h exp=0", PRDATA); end
        release_bus();
    endtask

    task automatic test_window_and_strb;
        setup(1'b1, 32'h1000, 32'h55AA55AA, 4'b1111, 3'b001);
        total++; if ({we, PREADY, PSLVERR} !== 3'b011) begin bad++; $display("FAIL oow_resp got=%b exp=011", {we, PREADY, PSLVERR}); end
        release_bus();
        setup(1'b1, 32'h40, 32'h11223344, 4'b0000, 3'b001);
        total++; if ({we, PREADY, PSLVERR} !== 3'b010) begin bad++; $display("FAIL zstrb_resp got=%b exp=010", {we, PREADY, PSLVERR}); end
        release_bus();
        total++; if ({we, PREADY} !== 2'b00) begin bad++; $display("FAIL zstrb_idle got=%b exp=00", {we, PREADY}); end
    endtask

    task automatic test_abort_and_protocol;
        setup(1'b0, 32'h50, 32'h0, 4'b0000, 3'b001);
        total++; if (re !== 1'b1) begin bad++; $display("FAIL abort_re got=%b exp=1", re); end
        release_bus();
        total++; if ({re, PREADY} !== 2'b00) begin bad++; $display("FAIL abort_drop got=%b exp=00", {re, PREADY}); end
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h90;
        tick();
        total++; if ({re, PREADY, PSLVERR} !== 3'b000) begin bad++; $display("FAIL proto_ignore got=%b exp=000", {re, PREADY, PSLVERR}); end
        release_bus();
    endtask

    task automatic test_back_to_back;
        setup(1'b1, 32'h80, 32'hA5A5A5A5, 4'b1000, 3'b001);
        slave_rdy = 1'b1;
        tick();
        total++; if (PREADY !== 1'b1) begin bad++; $display("FAIL b2b_first_pready got=%b exp=1", PREADY); end
        slave_rdy = 1'b0;
        tick();
        setup(1'b0, 32'h86, 32'h0, 4'b0000, 3'b001);
        total++; if ({re, addr} !== {1'b1, 32'h84}) begin bad++; $display("FAIL b2b_second got=%h exp=100000084", {re, addr}); end
        slave_rdy = 1'b1; rdata = 32'h0F0F0F0F;
        tick();
        total++; if (PRDATA !== 32'h0F0F0F0F) begin bad++; $display("FAIL b2b_prdata got=%h exp=0f0f0f0f", PRDATA); end
        release_bus();
    endtask

    task automatic test_pprot;
        setup(1'b0, 32'h70, 32'h0, 4'b0000, 3'b010);
`ifdef APB_PPROT_CHECK_EN
        total++; if ({re, PREADY, PSLVERR} !== 3'b011) begin bad++; $display("FAIL pprot_reject got=%b exp=011", {re, PREADY, PSLVERR}); end
`else
        total++; if (re !== 1'b1) begin bad++; $display("FAIL pprot_re got=%b exp=1", re); end
        slave_rdy = 1'b1; rdata = 32'h0BADF00D;
        tick();
        total++; if ({PREADY, PSLVERR, PRDATA} !== {2'b10, 32'h0BADF00D}) begin bad++; $display("FAIL pprot_read got=%h exp=20badf00d", {PREADY, PSLVERR, PRDATA}); end
`endif
        release_bus();
    endtask

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0;
        slave_rdy = 1'b0; rdata = '0;
        test_reset();
        test_write();
        test_read_wait();
        test_reset_mid();
        test_timeout();
        test_window_and_strb();
        test_abort_and_protocol();
        test_back_to_back();
        test_pprot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
